// File: rtl/linear_pkg.sv
// Shared types and arithmetic helpers for the linear_seq layer.
package linear_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_ROUND,
    S_DONE
  } state_t;

  // Widest accumulator and result the rounding helper handles; callers
  // sign-extend into these and slice the result back down.
  localparam int ACC_MAX = 128;
  localparam int RES_MAX = 64;

  typedef struct packed {
    logic                      sat;
    logic signed [RES_MAX-1:0] value;
  } round_t;

  // Bits needed to sum in_dim full-width products plus a shifted bias.
  function automatic int acc_width(input int in_dim, input int width);
    return 2 * width + $clog2(in_dim) + 1;
  endfunction

  // Round half away from zero, drop frac bits, clamp to a width-bit signed range.
  function automatic round_t round_sat(input logic signed [ACC_MAX-1:0] acc,
                                       input int frac, input int width);
    logic signed [ACC_MAX-1:0] half;
    logic signed [ACC_MAX-1:0] mag;
    logic signed [ACC_MAX-1:0] r;
    logic signed [ACC_MAX-1:0] hi;
    logic signed [ACC_MAX-1:0] lo;
    round_t res;
    half = (frac > 0) ? (ACC_MAX'(1) << (frac - 1)) : '0;
    if (acc[ACC_MAX-1]) begin
      mag = -acc;
      r   = -((mag + half) >>> frac);
    end else begin
      r = (acc + half) >>> frac;
    end
    hi        = (ACC_MAX'(1) << (width - 1)) - ACC_MAX'(1);
    lo        = -(ACC_MAX'(1) << (width - 1));
    res.sat   = 1'b0;
    res.value = r[RES_MAX-1:0];
    if (r > hi) begin
      res.sat   = 1'b1;
      res.value = hi[RES_MAX-1:0];
    end else if (r < lo) begin
      res.sat   = 1'b1;
      res.value = lo[RES_MAX-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: loads bias<<FRAC, then adds one product per enabled cycle.
module mac_lane #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] bias,
  input  logic signed [WIDTH-1:0] w,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;

  // Full-precision signed product of the current weight and input element.
  always_comb prod = w * x;

  // Accumulator: bias load takes priority over accumulation.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       acc <= '0;
    else if (load) acc <= ACC_W'(bias) <<< FRAC;
    else if (en)   acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/linear_seq.sv
// Sequential fixed-point dense layer: out = round_sat(W * in + bias), LANES rows at a time.
module linear_seq
  import linear_pkg::*;
#(
  parameter int IN_DIM  = 4,
  parameter int OUT_DIM = 4,
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int LANES   = 1,
  parameter int RELU    = 0,
  localparam int AW     = (OUT_DIM * IN_DIM > 1) ? $clog2(OUT_DIM * IN_DIM) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_DIM*WIDTH-1:0]    in_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_DIM*WIDTH-1:0]   out_vec,
  input  logic                       wr_en,
  input  logic                       wr_bias,
  input  logic [AW-1:0]              wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       sat
);

  localparam int G     = OUT_DIM / LANES;
  localparam int NW    = OUT_DIM * IN_DIM;
  localparam int ACC_W = acc_width(IN_DIM, WIDTH);
  localparam int KW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;

  if (OUT_DIM % LANES != 0) begin : g_bad_lanes
    $error("linear_seq: OUT_DIM must be a multiple of LANES");
  end
  if (ACC_W > ACC_MAX || WIDTH > RES_MAX) begin : g_bad_width
    $error("linear_seq: operand width exceeds rounding helper range");
  end

  state_t                    state, state_nx;
  logic [KW-1:0]             k;
  logic [GW-1:0]             grp;
  logic                      last_k, last_grp;
  logic                      accept, wr_ok, lane_load, lane_en;
  logic signed [WIDTH-1:0]   weight   [NW];
  logic signed [WIDTH-1:0]   bias     [OUT_DIM];
  logic signed [WIDTH-1:0]   bias_eff [OUT_DIM];
  logic signed [WIDTH-1:0]   x_reg    [IN_DIM];
  logic signed [WIDTH-1:0]   x_sel;
  logic signed [WIDTH-1:0]   w_sel    [LANES];
  logic signed [WIDTH-1:0]   b_sel    [LANES];
  logic signed [ACC_W-1:0]   acc      [LANES];
  round_t                    lane_rs  [LANES];
  logic [WIDTH-1:0]          lane_res [LANES];
  logic [LANES-1:0]          lane_sat;
  logic [LANES-1:0][RES_MAX-WIDTH-1:0] unused_rs_hi;

  assign last_k   = (k == KW'(IN_DIM - 1));
  assign last_grp = (grp == GW'(G - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid)  state_nx = S_MAC;
      S_MAC:   if (last_k)    state_nx = S_ROUND;
      S_ROUND: state_nx = last_grp ? S_DONE : S_MAC;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs and handshake strobes.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    lane_en   = (state == S_MAC);
    accept    = in_ready & in_valid;
    wr_ok     = wr_en & in_ready;
    lane_load = accept | ((state == S_ROUND) & ~last_grp);
  end

  // Element and group counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k   <= '0;
      grp <= '0;
    end else begin
      if (lane_en) k <= last_k ? '0 : k + KW'(1);
      if (accept)                             grp <= '0;
      else if ((state == S_ROUND) && !last_grp) grp <= grp + GW'(1);
    end
  end

  // Weight and bias storage; writes land only while idle.
  // NOTE: parameter storage is reset because a cleared layer must compute zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++)      weight[i] <= '0;
      for (int r = 0; r < OUT_DIM; r++) bias[r]   <= '0;
    end else if (wr_ok) begin
      if (wr_bias) begin
        for (int r = 0; r < OUT_DIM; r++) if (wr_addr == AW'(r)) bias[r] <= wr_data;
      end else begin
        for (int i = 0; i < NW; i++)      if (wr_addr == AW'(i)) weight[i] <= wr_data;
      end
    end
  end

  // Captured input vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < IN_DIM; j++) x_reg[j] <= '0;
    end else if (accept) begin
      for (int j = 0; j < IN_DIM; j++) x_reg[j] <= in_vec[j*WIDTH +: WIDTH];
    end
  end

  // Bias forwarding so a bias write on the accept edge feeds the first group load.
  always_comb begin
    for (int r = 0; r < OUT_DIM; r++)
      bias_eff[r] = (wr_ok && wr_bias && wr_addr == AW'(r)) ? wr_data : bias[r];
  end

  // Operand muxes: current input element, per-lane weight, per-lane bias to load.
  always_comb begin
    x_sel = '0;
    for (int j = 0; j < IN_DIM; j++) if (KW'(j) == k) x_sel = x_reg[j];
    for (int l = 0; l < LANES; l++) begin
      w_sel[l] = '0;
      b_sel[l] = '0;
      for (int i = 0; i < NW; i++)
        if (i == (int'(grp) * LANES + l) * IN_DIM + int'(k)) w_sel[l] = weight[i];
      for (int r = 0; r < OUT_DIM; r++)
        if (r == ((state == S_IDLE) ? l : (int'(grp) + 1) * LANES + l)) b_sel[l] = bias_eff[r];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (lane_load),
      .en   (lane_en),
      .bias (b_sel[l]),
      .w    (w_sel[l]),
      .x    (x_sel),
      .acc  (acc[l])
    );
  end

  // Round, saturate and optionally rectify each lane's accumulator.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_rs[l]      = round_sat(ACC_MAX'(acc[l]), FRAC, WIDTH);
      lane_sat[l]     = lane_rs[l].sat;
      lane_res[l]     = lane_rs[l].value[WIDTH-1:0];
      unused_rs_hi[l] = lane_rs[l].value[RES_MAX-1:WIDTH];
      if (RELU != 0 && lane_res[l][WIDTH-1]) lane_res[l] = '0;
    end
  end

  // Result vector and sticky saturation flag, written group by group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vec <= '0;
      sat     <= 1'b0;
    end else if (accept) begin
      sat <= 1'b0;
    end else if (state == S_ROUND) begin
      sat <= sat | (|lane_sat);
      for (int l = 0; l < LANES; l++)
        for (int r = 0; r < OUT_DIM; r++)
          if (r == int'(grp) * LANES + l) out_vec[r*WIDTH +: WIDTH] <= lane_res[l];
    end
  end

endmodule

// File: tb/tb_linear_seq.sv
// Bench for linear_seq: three configurations (plain, ReLU, two lanes) driven in lockstep.
module tb_linear_seq;

  typedef struct packed {
    logic [3:0][15:0] w;
    logic [1:0][15:0] b;
    logic [1:0][15:0] x;
    logic [1:0][15:0] e;
    logic             s;
  } vec_t;

  logic        clk, rst, in_valid, out_ready, wr_en, wr_bias;
  logic [31:0] in_vec;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  in_ready_w, out_valid_w, sat_w;
  logic [31:0] out_vec_w [3];

  logic [15:0] mw [4];
  logic [15:0] mb [2];
  vec_t        tab [5];
  int          n_checks = 0;
  int          n_fail   = 0;

  linear_seq #(.IN_DIM(2), .OUT_DIM(2), .WIDTH(16), .FRAC(8), .LANES(1), .RELU(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_vec(in_vec),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_vec(out_vec_w[0]), .wr_en(wr_en),
    .wr_bias(wr_bias), .wr_addr(wr_addr), .wr_data(wr_data), .sat(sat_w[0]));

  linear_seq #(.IN_DIM(2), .OUT_DIM(2), .WIDTH(16), .FRAC(8), .LANES(1), .RELU(1)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_vec(in_vec),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_vec(out_vec_w[1]), .wr_en(wr_en),
    .wr_bias(wr_bias), .wr_addr(wr_addr), .wr_data(wr_data), .sat(sat_w[1]));

  linear_seq #(.IN_DIM(2), .OUT_DIM(2), .WIDTH(16), .FRAC(8), .LANES(2), .RELU(0)) dut_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]), .in_vec(in_vec),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_vec(out_vec_w[2]), .wr_en(wr_en),
    .wr_bias(wr_bias), .wr_addr(wr_addr), .wr_data(wr_data), .sat(sat_w[2]));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: real-valued dot product in integer units, rounded half away from zero.
  function automatic logic [15:0] model_row(input int row, input logic [15:0] x0,
                                            input logic [15:0] x1, input bit relu, output bit s);
    longint acc, r;
    acc = longint'($signed(mb[row])) * 256
        + longint'($signed(mw[row*2]))   * longint'($signed(x0))
        + longint'($signed(mw[row*2+1])) * longint'($signed(x1));
    if (acc < 0) r = -((-acc + 128) / 256);
    else         r = (acc + 128) / 256;
    s = 1'b0;
    if (r > 32767)       begin r = 32767;  s = 1'b1; end
    else if (r < -32768) begin r = -32768; s = 1'b1; end
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 1023)) - 16'd512;
  endfunction

  // Called and returns just after a falling edge.
  task automatic write_param(input bit b, input int a, input logic [15:0] v);
    wr_en = 1'b1; wr_bias = b; wr_addr = 2'(a); wr_data = v;
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0;
    if (b) mb[a] = v; else mw[a] = v;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 4; i++) write_param(1'b0, i, v.w[i]);
    for (int i = 0; i < 2; i++) write_param(1'b1, i, v.b[i]);
  endtask

  task automatic run_vec(input logic [15:0] x0, input logic [15:0] x1, input int hold,
                         input bit co_wr, input bit co_b, input int co_a, input logic [15:0] co_d,
                         input bit mid_wr, input bit use_tab, input vec_t tv, input string tag);
    logic [31:0] exp_vec [3];
    logic [2:0]  exp_sat;
    int          lat [3];
    bit [2:0]    seen;
    bit          s0, s1;
    logic [15:0] e0, e1, t0, t1;

    in_vec = {x1, x0}; in_valid = 1'b1;
    if (co_wr) begin wr_en = 1'b1; wr_bias = co_b; wr_addr = 2'(co_a); wr_data = co_d; end
    check({tag, " in_ready idle"}, 64'(in_ready_w), 64'(3'b111));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; wr_en = 1'b0;
    if (co_wr) begin if (co_b) mb[co_a] = co_d; else mw[co_a] = co_d; end
    for (int d = 0; d < 3; d++) begin
      e0 = model_row(0, x0, x1, d == 1, s0);
      e1 = model_row(1, x0, x1, d == 1, s1);
      exp_vec[d] = {e1, e0};
      exp_sat[d] = s0 | s1;
    end
    check({tag, " in_ready busy"}, 64'(in_ready_w), 64'(0));

    seen = '0;
    lat  = '{-1, -1, -1};
    for (int c = 1; c <= 40 && seen != 3'b111; c++) begin
      if (mid_wr && c == 1) begin
        wr_en = 1'b1; wr_bias = 1'b0; wr_addr = 2'd0; wr_data = 16'h1234;
        in_valid = 1'b1; in_vec = 32'hDEAD_BEEF;
      end
      if (mid_wr && c == 2) begin wr_bias = 1'b1; wr_data = 16'h4321; end
      if (mid_wr && c == 3) wr_en = 1'b0;
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 3; d++)
        if (!seen[d] && out_valid_w[d]) begin seen[d] = 1'b1; lat[d] = c; end
    end
    wr_en = 1'b0; in_valid = 1'b0;
    for (int d = 0; d < 3; d++)
      check($sformatf("%s latency d%0d", tag, d), 64'(lat[d]), 64'((d == 2) ? 3 : 6));

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("%s hold%0d out_valid", tag, h), 64'(out_valid_w), 64'(3'b111));
      check($sformatf("%s hold%0d in_ready", tag, h), 64'(in_ready_w), 64'(0));
      for (int d = 0; d < 3; d++)
        check($sformatf("%s hold%0d out_vec d%0d", tag, h, d), 64'(out_vec_w[d]), 64'(exp_vec[d]));
    end

    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s out_vec d%0d", tag, d), 64'(out_vec_w[d]), 64'(exp_vec[d]));
      check($sformatf("%s sat d%0d", tag, d), 64'(sat_w[d]), 64'(exp_sat[d]));
      if (use_tab) begin
        t0 = tv.e[0]; t1 = tv.e[1];
        if (d == 1 && t0[15]) t0 = 16'h0;
        if (d == 1 && t1[15]) t1 = 16'h0;
        check($sformatf("%s table out_vec d%0d", tag, d), 64'(out_vec_w[d]), 64'({t1, t0}));
        check($sformatf("%s table sat d%0d", tag, d), 64'(sat_w[d]), 64'(tv.s));
      end
    end

    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, " in_ready after take"}, 64'(in_ready_w), 64'(3'b111));
    check({tag, " out_valid after take"}, 64'(out_valid_w), 64'(0));
  endtask

  initial begin
    bit          bad;
    bit          co_b;
    int          co_a;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_bias = 1'b0; wr_addr = '0; wr_data = '0; in_vec = '0;
    for (int i = 0; i < 4; i++) mw[i] = '0;
    for (int i = 0; i < 2; i++) mb[i] = '0;

    for (int t = 0; t < 5; t++) tab[t] = '0;
    tab[0].w[0] = 16'h0080; tab[0].w[1] = 16'h0100; tab[0].w[2] = 16'hFF00;
    tab[0].b[0] = 16'h0040; tab[0].x[0] = 16'h0100; tab[0].x[1] = 16'h0200;
    tab[0].e[0] = 16'h02C0; tab[0].e[1] = 16'hFF00;
    tab[1].w[0] = 16'h0080; tab[1].x[0] = 16'h0001; tab[1].e[0] = 16'h0001;
    tab[2].w[0] = 16'h0080; tab[2].x[0] = 16'hFFFF; tab[2].e[0] = 16'hFFFF;
    tab[3].w[0] = 16'h7FFF; tab[3].w[1] = 16'h7FFF; tab[3].x[0] = 16'h7FFF; tab[3].x[1] = 16'h7FFF;
    tab[3].e[0] = 16'h7FFF; tab[3].s = 1'b1;
    tab[4].w[0] = 16'h7FFF; tab[4].w[1] = 16'h7FFF; tab[4].x[0] = 16'h8000; tab[4].x[1] = 16'h8000;
    tab[4].e[0] = 16'h8000; tab[4].s = 1'b1;

    #3;
    check("reset in_ready", 64'(in_ready_w), 64'(3'b111));
    check("reset out_valid", 64'(out_valid_w), 64'(0));
    check("reset sat", 64'(sat_w), 64'(0));
    for (int d = 0; d < 3; d++) check($sformatf("reset out_vec d%0d", d), 64'(out_vec_w[d]), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Directed table vectors; the first one also holds off the consumer for 5 cycles.
    for (int t = 0; t < 5; t++) begin
      load_vec(tab[t]);
      run_vec(tab[t].x[0], tab[t].x[1], (t == 0) ? 5 : 0, 1'b0, 1'b0, 0, 16'h0,
              1'b0, 1'b1, tab[t], $sformatf("tab%0d", t));
    end

    // Writes and stray in_valid during the computation must not disturb the result.
    load_vec(tab[0]);
    run_vec(16'h0100, 16'h0200, 0, 1'b0, 1'b0, 0, 16'h0, 1'b1, 1'b1, tab[0], "midwr");
    // A bias write on the accept edge takes effect for that computation.
    run_vec(16'h0100, 16'h0200, 0, 1'b1, 1'b1, 0, 16'h0000, 1'b0, 1'b0, tab[0], "cowr");

    // Reset in the middle of a computation.
    in_vec = {16'h0200, 16'h0100}; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst in_ready", 64'(in_ready_w), 64'(3'b111));
    check("midrst out_valid", 64'(out_valid_w), 64'(0));
    check("midrst sat", 64'(sat_w), 64'(0));
    for (int d = 0; d < 3; d++) check($sformatf("midrst out_vec d%0d", d), 64'(out_vec_w[d]), 64'(0));
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) mw[i] = '0;
    for (int i = 0; i < 2; i++) mb[i] = '0;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid_w != 0 || in_ready_w != 3'b111) bad = 1'b1;
    end
    check("midrst no output", 64'(bad), 64'(0));
    run_vec(16'h0100, 16'h0200, 0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0, tab[0], "cleared");

    // Randomized parameters, inputs, hold-off and accept-edge writes against the model.
    for (int it = 0; it < 24; it++) begin
      for (int n = $urandom_range(0, 3); n > 0; n--) begin
        co_b = 1'($urandom_range(0, 1));
        write_param(co_b, co_b ? $urandom_range(0, 1) : $urandom_range(0, 3), rnd16());
      end
      co_b = 1'($urandom_range(0, 1));
      co_a = co_b ? $urandom_range(0, 1) : $urandom_range(0, 3);
      run_vec(rnd16(), rnd16(), $urandom_range(0, 2), 1'($urandom_range(0, 1)), co_b, co_a,
              rnd16(), 1'b0, 1'b0, tab[0], $sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linear_seq.md
LINEAR_SEQ -- requirements
Module: linear_seq

Interface
REQ-001 SHALL have parameter IN_DIM, default 4: input vector length.
REQ-002 SHALL have parameter OUT_DIM, default 4: output vector length.
REQ-003 SHALL have parameter WIDTH, default 16: signed fixed-point element width.
REQ-004 SHALL have parameter FRAC, default 8: fractional bits of all operands and results.
REQ-005 SHALL have parameter LANES, default 1: parallel MAC lanes; OUT_DIM % LANES == 0, else elaboration error.
REQ-006 SHALL have parameter RELU, default 0: 1 = clamp negative outputs to zero.
REQ-007 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port in_valid, input, 1: in_vec valid.
REQ-010 SHALL have port in_ready, output, 1: block can accept a vector.
REQ-011 SHALL have port in_vec, input, IN_DIM*WIDTH: signed elements; element i at [i*WIDTH +: WIDTH].
REQ-012 SHALL have port out_valid, output, 1: out_vec holds a result.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-014 SHALL have port out_vec, output, OUT_DIM*WIDTH: signed results, same packing as in_vec.
REQ-015 SHALL have port wr_en, input, 1: parameter write strobe.
REQ-016 SHALL have port wr_bias, input, 1: 1 = write bias[wr_addr], 0 = write weight[wr_addr] (row-major, o*IN_DIM+i).
REQ-017 SHALL have port wr_addr, input, $clog2(OUT_DIM*IN_DIM), min 1: parameter index.
REQ-018 SHALL have port wr_data, input, WIDTH: parameter value.
REQ-019 SHALL have port sat, output, 1: at least one element of the current result saturated.

Function
REQ-020 SHALL implement FSM IDLE -> MAC -> ROUND -> (MAC for next group | DONE) -> IDLE.
REQ-021 SHALL assert in_ready only in IDLE; an input is accepted on in_valid & in_ready, in_vec registered internally.
REQ-022 SHALL process outputs in G = OUT_DIM/LANES groups of LANES rows; per group, accumulators are loaded with sign-extended bias<<FRAC, then run IN_DIM MAC cycles, one product per lane per cycle.
REQ-023 SHALL use accumulator width 2*WIDTH + $clog2(IN_DIM) + 1, with no internal overflow.
REQ-024 SHALL in ROUND round half away from zero: negative acc -> -((|acc| + 2^(FRAC-1)) >> FRAC), non-negative -> (acc + 2^(FRAC-1)) >> FRAC.
REQ-025 SHALL saturate the rounded value to [-2^(WIDTH-1), 2^(WIDTH-1)-1], set sat sticky for the result, then apply ReLU when RELU=1.
REQ-026 SHALL assert out_valid exactly G*(IN_DIM+1) cycles after the accept edge; out_vec and sat are stable while out_valid=1.
REQ-027 SHALL hold DONE until out_ready; on out_valid & out_ready return to IDLE, in_ready=1 the next cycle.
REQ-028 SHALL apply parameter writes only in IDLE; writes in other states are silently dropped.
REQ-029 SHALL apply a write coinciding with an accept edge before the computation uses it.
REQ-030 SHALL ignore in_valid outside IDLE; no input is lost or double-counted.

Reset
REQ-031 SHALL on rst force IDLE, in_ready=1, out_valid=0, out_vec=0, sat=0, accumulators and counters 0, asynchronously.
REQ-032 SHALL abort any computation in progress when reset asserts mid-operation, with no output produced.
REQ-033 SHALL clear weights and biases to 0 on reset.

Structure
REQ-034 SHALL place the state enum, acc-width function and round/saturate function in package linear_pkg.
REQ-035 SHALL instantiate sub-module mac_lane (multiply, accumulate, bias load) LANES times.

Verification
Config for REQ-036..040: IN_DIM=2, OUT_DIM=2, WIDTH=16, FRAC=8, LANES=1.
REQ-036 SHALL cover arithmetic: W0=[0x0080,0x0100], b0=0x0040, W1=[0xFF00,0], b1=0, in=[0x0100,0x0200] -> out=[0x02C0,0xFF00], out_valid 6 cycles after accept, sat=0.
REQ-037 SHALL cover RELU=1 on the REQ-036 vector -> out=[0x02C0,0x0000].
REQ-038 SHALL cover rounding: W0=[0x0080,0], in=[0x0001,0] -> 0x0001; in=[0xFFFF,0] -> 0xFFFF.
REQ-039 SHALL cover saturation: W0=[0x7FFF,0x7FFF], in=[0x7FFF,0x7FFF] -> 0x7FFF with sat=1; in=[0x8000,0x8000] -> 0x8000 with sat=1.
REQ-040 SHALL cover backpressure and boundaries: out_ready low 5 cycles -> out_vec held, in_ready=0; wr_en during MAC -> result unchanged; rst at cycle 3 of MAC -> out_valid never asserts, in_ready=1.
REQ-041 SHALL cover LANES=2 on the REQ-036 vectors -> same outputs, out_valid 3 cycles after accept.
